ov2640_config_sequencer: RTL and testbench

Sequences the OV2640 configuration ROM into the sensor over SCCB after power-up or on request. It walks ROM addresses from 0 and splits each 16-bit word into {register, value}. Each write goes to the SCCB master through a request/acknowledge/done handshake. Delay entries and the end marker are interpreted, and the block reports completion or failure to the camera top level.

---
 rtl/ov2640_cfg_pkg.sv | 23 ++
 rtl/ov2640_ms_timer.sv | 47 ++++
 rtl/ov2640_config_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ov2640_config_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov2640_cfg_pkg.sv
// Shared types and constants for the OV2640 configuration sequencer.
package ov2640_cfg_pkg;

  // Sequencer states, in the order an entry normally flows through them.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_REQ,
    S_WAIT,
    S_DELAY,
    S_DONE,
    S_ERR
  } state_e;

  // ROM word that terminates the configuration table.
  localparam logic [15:0] END_MARK  = 16'hFFFF;
  // Pseudo-register: the value byte is a wait time in milliseconds.
  localparam logic [7:0]  DELAY_REG = 8'hFE;
  // Sensor bank-select register; written like any other register.
  localparam logic [7:0]  BANK_REG  = 8'hFF;

endpackage

// File: rtl/ov2640_ms_timer.sv
// Millisecond delay timer: a free-running prescaler producing a one-cycle
// tick every CLK_FREQ_HZ/1000 cycles, and a loadable 8-bit down-counter
// that decrements on each tick and flags when it reaches zero.
module ov2640_ms_timer #(
  parameter int CLK_FREQ_HZ = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o
);

  localparam int DIV = ((CLK_FREQ_HZ / 1000) < 1) ? 1 : (CLK_FREQ_HZ / 1000);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          tick;

  assign tick   = (pre_q == PRE_MAX);
  assign zero_o = (cnt_q == 8'd0);

  // Prescaler wraps on the tick; a load takes priority over a tick decrement.
  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick && !zero_o) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= 8'd0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ov2640_config_sequencer.sv
// Walks the OV2640 configuration ROM from address 0, issuing one SCCB write
// per {register, value} entry, honouring millisecond delay entries and the
// end marker, retrying NACKed writes and reporting completion or failure.
module ov2640_config_sequencer
  import ov2640_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  output logic [ADDR_WIDTH-1:0] Rom_Addr,
  input  logic [DATA_WIDTH-1:0] Rom_Data,
  output logic                  Sccb_Req,
  output logic [7:0]            Sccb_Reg,
  output logic [7:0]            Sccb_Val,
  input  logic                  Sccb_Ack,
  input  logic                  Sccb_Done,
  input  logic                  Sccb_Err,
  output logic                  Busy,
  output logic                  Config_Done,
  output logic                  Config_Err,
  output logic [ADDR_WIDTH-1:0] Err_Addr
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0] entry_q, entry_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic advance;     // current entry finished, move to the next ROM word
  logic xfer_done;   // SCCB transaction finished this cycle
  logic timer_load;
  logic timer_zero;

  ov2640_ms_timer #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_ms_timer (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .load_i    (timer_load),
    .load_val_i(entry_q[7:0]),
    .zero_o    (timer_zero)
  );

  // Next-state logic for the sequencer and its address/entry/retry registers.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    entry_d    = entry_q;
    retry_d    = retry_q;
    err_addr_d = err_addr_q;
    advance    = 1'b0;
    xfer_done  = 1'b0;
    timer_load = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          rom_addr_d = '0;
          retry_d    = '0;
          err_addr_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        entry_d = Rom_Data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (entry_q == END_MARK) begin
          state_d = S_DONE;
        end else if (entry_q[15:8] == DELAY_REG) begin
          if (entry_q[7:0] == 8'd0) begin
            advance = 1'b1;
          end else begin
            timer_load = 1'b1;
            state_d    = S_DELAY;
          end
        end else begin
          // Bank-select writes (BANK_REG) take this path like any register.
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Ack and Done together complete the entry without a WAIT cycle.
        if (Sccb_Ack) begin
          if (Sccb_Done) xfer_done = 1'b1;
          else           state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (Sccb_Done) xfer_done = 1'b1;
      end
      S_DELAY: begin
        if (timer_zero) advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (xfer_done) begin
      if (!Sccb_Err) begin
        advance = 1'b1;
      end else if (retry_q < MAX_RETRY_C) begin
        retry_d = retry_q + 1'b1;
        state_d = S_REQ;
      end else begin
        err_addr_d = rom_addr_q;
        state_d    = S_ERR;
      end
    end

    // A table that runs off the end of the ROM without a marker is an error,
    // reported against the last address rather than wrapping to 0.
    if (advance) begin
      if (rom_addr_q == '1) begin
        err_addr_d = rom_addr_q;
        state_d    = S_ERR;
      end else begin
        rom_addr_d = rom_addr_q + 1'b1;
        retry_d    = '0;
        state_d    = S_FETCH;
      end
    end
  end

  // Sequencer registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      entry_q    <= '0;
      retry_q    <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      entry_q    <= entry_d;
      retry_q    <= retry_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Outputs decode directly from registered state, so reset drops the
  // request asynchronously.
  assign Rom_Addr    = rom_addr_q;
  assign Sccb_Req    = (state_q == S_REQ);
  assign Sccb_Reg    = entry_q[15:8];
  assign Sccb_Val    = entry_q[7:0];
  assign Busy        = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign Config_Done = (state_q == S_DONE);
  assign Config_Err  = (state_q == S_ERR);
  assign Err_Addr    = err_addr_q;

endmodule

// File: tb/tb_ov2640_config_sequencer.sv
// Directed bench for ov2640_config_sequencer: a small ROM array, an SCCB
// master model with programmable Done latency and per-request NACKs, and a
// linear sequence of scenarios with hand-computed expectations.
module tb_ov2640_config_sequencer;

  localparam int AW = 3;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Start = 1'b0;
  logic [AW-1:0] Rom_Addr;
  logic [15:0]   Rom_Data;
  logic          Sccb_Req;
  logic [7:0]    Sccb_Reg;
  logic [7:0]    Sccb_Val;
  logic          Sccb_Ack = 1'b0;
  logic          Sccb_Done = 1'b0;
  logic          Sccb_Err = 1'b0;
  logic          Busy;
  logic          Config_Done;
  logic          Config_Err;
  logic [AW-1:0] Err_Addr;

  logic [15:0] rom [0:7];
  assign Rom_Data = rom[Rom_Addr];

  ov2640_config_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (16),
    .CLK_FREQ_HZ(1000),
    .MAX_RETRY  (3)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Start      (Start),
    .Rom_Addr   (Rom_Addr),
    .Rom_Data   (Rom_Data),
    .Sccb_Req   (Sccb_Req),
    .Sccb_Reg   (Sccb_Reg),
    .Sccb_Val   (Sccb_Val),
    .Sccb_Ack   (Sccb_Ack),
    .Sccb_Done  (Sccb_Done),
    .Sccb_Err   (Sccb_Err),
    .Busy       (Busy),
    .Config_Done(Config_Done),
    .Config_Err (Config_Err),
    .Err_Addr   (Err_Addr)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  // Master model state and logs (written only by the master process).
  int         done_lat = 10;
  bit         err_plan [0:63];
  int         req_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] log_reg [0:63];
  logic [7:0] log_val [0:63];
  int         req_cyc [0:63];
  int         done_cyc [0:63];
  bit         pending = 1'b0;
  bit         pend_err = 1'b0;
  int         cd = 0;

  // SCCB master: acks a request at once, reports Done done_lat cycles later
  // (same cycle as Ack when done_lat is 0), with Err taken from err_plan.
  always @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Sccb_Ack  = 1'b0;
      Sccb_Done = 1'b0;
      Sccb_Err  = 1'b0;
      pending   = 1'b0;
      cd        = 0;
    end else begin
      Sccb_Ack  = 1'b0;
      Sccb_Done = 1'b0;
      Sccb_Err  = 1'b0;
      if (pending) begin
        if (cd == 0) begin
          Sccb_Done = 1'b1;
          Sccb_Err  = pend_err;
          pending   = 1'b0;
          if (done_cnt < 64) done_cyc[done_cnt] = cyc;
          done_cnt++;
        end else begin
          cd--;
        end
      end else if (Sccb_Req && req_cnt < 64) begin
        Sccb_Ack         = 1'b1;
        log_reg[req_cnt] = Sccb_Reg;
        log_val[req_cnt] = Sccb_Val;
        req_cyc[req_cnt] = cyc;
        pend_err         = err_plan[req_cnt];
        req_cnt++;
        if (done_lat == 0) begin
          Sccb_Done = 1'b1;
          Sccb_Err  = pend_err;
          done_cyc[done_cnt] = cyc;
          done_cnt++;
        end else begin
          pending = 1'b1;
          cd      = done_lat - 1;
        end
      end
    end
  end

  int total = 0;
  int bad = 0;
  int start_cyc = 0;
  int end_cyc = 0;
  int rb = 0;
  int db = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    Start     = 1'b1;
    start_cyc = cyc;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(Config_Done || Config_Err) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    end_cyc = cyc;
    check("end_reached", 32'(Config_Done | Config_Err), 32'd1);
  endtask

  task automatic load_rom(input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7);
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    rom[4] = w4; rom[5] = w5; rom[6] = w6; rom[7] = w7;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) err_plan[i] = 1'b0;
    load_rom(16'hFF00, 16'h2CFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Reset state.
    repeat (3) @(negedge Clk);
    check("rst_rom_addr", 32'(Rom_Addr), 32'd0);
    check("rst_outputs", {27'd0, Sccb_Req, Busy, Config_Done, Config_Err, 1'b0}, 32'd0);
    check("rst_err_addr", 32'(Err_Addr), 32'd0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Basic table: two writes, Done 10 cycles after Ack; Start while busy ignored.
    done_lat = 10;
    rb = req_cnt; db = done_cnt;
    pulse_start();
    check("busy_after_start", 32'(Busy), 32'd1);
    repeat (5) @(negedge Clk);
    pulse_start();
    wait_end(400);
    check("basic_done", 32'(Config_Done), 32'd1);
    check("basic_busy", 32'(Busy), 32'd0);
    check("basic_nreq", 32'(req_cnt - rb), 32'd2);
    check("basic_w0", {16'd0, log_reg[rb], log_val[rb]}, 32'h0000FF00);
    check("basic_w1", {16'd0, log_reg[rb+1], log_val[rb+1]}, 32'h00002CFF);
    check("start_to_req", 32'(req_cyc[rb] - (start_cyc - 6)), 32'd3);
    check("done_to_req", 32'(req_cyc[rb+1] - done_cyc[db]), 32'd3);
    check("done_to_cfgdone", 32'(end_cyc - done_cyc[db+1]), 32'd3);

    // Restart from DONE with Ack and Done in the same cycle.
    done_lat = 0;
    rb = req_cnt;
    pulse_start();
    check("rerun_done_cleared", 32'(Config_Done), 32'd0);
    check("rerun_busy", 32'(Busy), 32'd1);
    wait_end(400);
    check("rerun_done", 32'(Config_Done), 32'd1);
    check("rerun_nreq", 32'(req_cnt - rb), 32'd2);
    check("rerun_w1", {16'd0, log_reg[rb+1], log_val[rb+1]}, 32'h00002CFF);
    check("rerun_start_to_req", 32'(req_cyc[rb] - start_cyc), 32'd3);

    // Delay entries: FE05 = 5 one-cycle ticks, FE00 = no wait.
    load_rom(16'hFE05, 16'h1234, 16'hFE00, 16'h5678, 16'hFFFF, 16'h0, 16'h0, 16'h0);
    done_lat = 2;
    rb = req_cnt; db = done_cnt;
    pulse_start();
    wait_end(400);
    check("delay_done", 32'(Config_Done), 32'd1);
    check("delay_nreq", 32'(req_cnt - rb), 32'd2);
    check("delay5_start_to_req", 32'(req_cyc[rb] - start_cyc), 32'd11);
    check("delay0_done_to_req", 32'(req_cyc[rb+1] - done_cyc[db]), 32'd5);
    check("delay_w0", {16'd0, log_reg[rb], log_val[rb]}, 32'h00001234);
    check("delay_w1", {16'd0, log_reg[rb+1], log_val[rb+1]}, 32'h00005678);

    // Three NACKs on entry 2, then success.
    load_rom(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hFFFF, 16'h0, 16'h0, 16'h0);
    done_lat = 3;
    rb = req_cnt; db = done_cnt;
    err_plan[rb+2] = 1'b1; err_plan[rb+3] = 1'b1; err_plan[rb+4] = 1'b1;
    pulse_start();
    wait_end(600);
    check("retry_done", 32'(Config_Done), 32'd1);
    check("retry_nreq", 32'(req_cnt - rb), 32'd7);
    check("retry_entry2_x4", {log_reg[rb+2], log_reg[rb+3], log_reg[rb+4], log_reg[rb+5]}, 32'h33333333);
    check("retry_then_next", 32'(log_reg[rb+6]), 32'h44);
    check("nack_to_req", 32'(req_cyc[rb+3] - done_cyc[db+2]), 32'd1);

    // Four NACKs on entry 2: abort.
    rb = req_cnt;
    err_plan[rb+2] = 1'b1; err_plan[rb+3] = 1'b1;
    err_plan[rb+4] = 1'b1; err_plan[rb+5] = 1'b1;
    pulse_start();
    wait_end(600);
    check("abort_err", 32'(Config_Err), 32'd1);
    check("abort_done", 32'(Config_Done), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_err_addr", 32'(Err_Addr), 32'd2);
    check("abort_nreq", 32'(req_cnt - rb), 32'd6);

    // No end marker: runs to address 7 and errors without wrapping.
    load_rom(16'h1001, 16'h1102, 16'h1203, 16'h1304, 16'h1405, 16'h1506, 16'h1607, 16'h1708);
    done_lat = 1;
    rb = req_cnt;
    pulse_start();
    check("nomark_err_cleared", 32'(Config_Err), 32'd0);
    wait_end(600);
    check("nomark_err", 32'(Config_Err), 32'd1);
    check("nomark_err_addr", 32'(Err_Addr), 32'd7);
    check("nomark_no_wrap", 32'(Rom_Addr), 32'd7);
    check("nomark_nreq", 32'(req_cnt - rb), 32'd8);
    check("nomark_last", {16'd0, log_reg[rb+7], log_val[rb+7]}, 32'h00001708);

    // Reset while the second request is up, then restart from address 0.
    load_rom(16'hAB01, 16'hCD02, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    done_lat = 10;
    pulse_start();
    begin
      int n = 0;
      while (!(Sccb_Req && Rom_Addr == 3'd1) && n < 200) begin
        @(negedge Clk);
        n++;
      end
    end
    check("rst_req_seen", 32'(Sccb_Req), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("rst_req_drop", 32'(Sccb_Req), 32'd0);
    check("rst_mid_busy", 32'(Busy), 32'd0);
    check("rst_mid_addr", 32'(Rom_Addr), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    rb = req_cnt;
    pulse_start();
    wait_end(400);
    check("restart_done", 32'(Config_Done), 32'd1);
    check("restart_nreq", 32'(req_cnt - rb), 32'd2);
    check("restart_first", {16'd0, log_reg[rb], log_val[rb]}, 32'h0000AB01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
